register_stack_param: RTL and testbench
=======================================

REGISTER_STACK_PARAM -- requirements
Module: register_stack_param

Parameters
REQ-001 SHALL have parameter WIDTH, default 16, data word width in bits (WIDTH >= 2).
REQ-002 SHALL have parameter DEPTH, default 64, number of stack entries (DEPTH >= 2).

Interface
REQ-003 SHALL have port CLK, input, 1 bit, single clock; all state updates on rising edge.
REQ-004 SHALL have port reset, input, 1 bit, asynchronous active-high reset.
REQ-005 SHALL have port stackOP, input, 3 bits: 0 NOP, 1 PUSH, 2 REPLACE, 3 POP, 4 POP2, 5 SWAP, 6 DUP, 7 OVER.
REQ-006 SHALL have port w, input, WIDTH bits, write data for PUSH and REPLACE.
REQ-007 SHALL have port clr_err, input, 1 bit, synchronous clear of the sticky error flags.
REQ-008 SHALL have port a, output, WIDTH bits, top of stack (entry 0).
REQ-009 SHALL have port b, output, WIDTH bits, second entry (entry 1).
REQ-010 SHALL have port count, output, clog2(DEPTH+1) bits, number of valid entries.
REQ-011 SHALL have ports full and empty, outputs, 1 bit each: full = (count == DEPTH); empty = (count == 0).
REQ-012 SHALL have ports ovf and unf, outputs, 1 bit each, sticky overflow and underflow flags.

Function
REQ-013 Storage SHALL be DEPTH registers, entry 0 = top; a and b SHALL be driven directly from entries 0 and 1 (no output latency; the new value is visible after the op's clock edge).
REQ-014 PUSH SHALL shift all entries down by one, write w into entry 0, and discard entry DEPTH-1.
REQ-015 POP SHALL shift all entries up by one and load 0 into entry DEPTH-1.
REQ-016 POP2 SHALL shift up by two and load 0 into entries DEPTH-2 and DEPTH-1.
REQ-017 REPLACE SHALL shift up by one and then overwrite entry 0 with w, so that new a = w and new b = old entry 2.
REQ-018 SWAP SHALL exchange entries 0 and 1; all other entries SHALL be unchanged.
REQ-019 DUP SHALL act as PUSH of old a; OVER SHALL act as PUSH of old b.
REQ-020 NOP SHALL leave every register unchanged.
REQ-021 count SHALL update as follows:
  - PUSH, DUP, OVER: +1, saturating at DEPTH.
  - POP: -1, saturating at 0.
  - POP2: -2, saturating at 0.
  - REPLACE: max(count-1, 1).
  - SWAP, NOP: unchanged.
REQ-022 ovf SHALL be set on any PUSH, DUP or OVER issued while full; the data shift SHALL still occur, losing the bottom entry.
REQ-023 unf SHALL be set when an op needs more valid entries than count holds, and the data operation SHALL still be performed:
  - POP with count 0.
  - POP2 with count < 2.
  - REPLACE with count < 2.
  - SWAP with count < 2.
  - DUP with count 0.
  - OVER with count < 2.
REQ-024 ovf and unf SHALL remain set until reset or clr_err; clr_err SHALL clear both flags at the next edge.
REQ-025 When clr_err is asserted in the same cycle as a new error, the flag for the new error SHALL end up set (set wins).
REQ-026 stackOP values SHALL be decoded every cycle with no handshake; exactly one op SHALL be applied per rising edge.

Reset
REQ-027 While reset = 1, all entries SHALL be 0, count = 0, ovf = unf = 0, a = b = 0, empty = 1, full = 0, independent of CLK.
REQ-028 A reset asserted mid-sequence SHALL take effect immediately; the op present on the first rising edge after reset deasserts SHALL execute normally.

Verification
REQ-029 PUSH 1, PUSH 4, REPLACE w=5 -> a=5, b=0, count=1, unf=0.
REQ-030 PUSH 2, PUSH 4, POP -> a=2, count=1; POP -> a=0, count=0, unf=0; POP -> a=0, count=0, unf=1; clr_err -> unf=0.
REQ-031 PUSH 1, PUSH 2, SWAP -> a=1, b=2; OVER -> a=2, b=1, count=3; DUP -> a=2, b=2, count=4.
REQ-032 DEPTH=64: PUSH 1..64 -> full=1, ovf=0; PUSH 65 -> ovf=1, count=64; 63 POPs -> a=2; 64th POP -> a=0, empty=1.
REQ-033 PUSH 2,4,3,5, POP2 -> a=4, count=2; POP2 -> a=0, count=0, unf=0; POP2 -> unf=1.
REQ-034 PUSH 7, then assert reset asynchronously between clock edges -> a=0, count=0 before the next edge.
REQ-035 Repeat REQ-032 with WIDTH=8, DEPTH=4: PUSH 255 five times -> ovf=1, count=4, a=255; PUSH 1 five times -> ovf=1, count=4, a=1.

Source files
------------

// File: rtl/register_stack_param.sv
// register_stack_param
// Parameterised register stack. Entry 0 is the top of stack and is driven
// straight onto a, with entry 1 on b. Every cycle one operation is decoded
// from stackOP and applied at the rising edge of CLK. Overflow and underflow
// are reported through sticky flags. The data movement is always carried out
// in full, even when an op raises an error.
module register_stack_param #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 64
) (
    input  logic                       CLK,
    input  logic                       reset,
    input  logic [2:0]                 stackOP,
    input  logic [WIDTH-1:0]           w,
    input  logic                       clr_err,
    output logic [WIDTH-1:0]           a,
    output logic [WIDTH-1:0]           b,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       full,
    output logic                       empty,
    output logic                       ovf,
    output logic                       unf
);

    localparam int CW = $clog2(DEPTH + 1);

    localparam logic [2:0] OP_NOP     = 3'd0;
    localparam logic [2:0] OP_PUSH    = 3'd1;
    localparam logic [2:0] OP_REPLACE = 3'd2;
    localparam logic [2:0] OP_POP     = 3'd3;
    localparam logic [2:0] OP_POP2    = 3'd4;
    localparam logic [2:0] OP_SWAP    = 3'd5;
    localparam logic [2:0] OP_DUP     = 3'd6;
    localparam logic [2:0] OP_OVER    = 3'd7;

    localparam logic [CW-1:0] CNT_ZERO = '0;
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [CW-1:0] CNT_TWO  = CW'(2);
    localparam logic [CW-1:0] CNT_MAX  = CW'(DEPTH);

    logic [WIDTH-1:0] stk     [DEPTH];
    logic [WIDTH-1:0] stk_nxt [DEPTH];
    logic [WIDTH-1:0] push_val;
    logic             is_push;
    logic [CW-1:0]    cnt;
    logic [CW-1:0]    cnt_nxt;
    logic             ovf_set;
    logic             unf_set;

    // The three push-type ops share a single shift-down path. Only the value
    // written into entry 0 differs between them.
    always_comb begin
        is_push  = 1'b0;
        push_val = w;
        case (stackOP)
            OP_PUSH: begin
                is_push  = 1'b1;
                push_val = w;
            end
            OP_DUP: begin
                is_push  = 1'b1;
                push_val = stk[0];
            end
            OP_OVER: begin
                is_push  = 1'b1;
                push_val = stk[1];
            end
            default: begin
                is_push  = 1'b0;
                push_val = w;
            end
        endcase
    end

    // Next contents of the storage array for the decoded op.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            stk_nxt[i] = stk[i];
        end
        if (is_push) begin
            for (int i = DEPTH - 1; i > 0; i--) begin
                stk_nxt[i] = stk[i-1];
            end
            stk_nxt[0] = push_val;
        end else begin
            case (stackOP)
                OP_POP: begin
                    for (int i = 0; i < DEPTH - 1; i++) begin
                        stk_nxt[i] = stk[i+1];
                    end
                    stk_nxt[DEPTH-1] = '0;
                end
                OP_POP2: begin
                    for (int i = 0; i < DEPTH - 2; i++) begin
                        stk_nxt[i] = stk[i+2];
                    end
                    stk_nxt[DEPTH-2] = '0;
                    stk_nxt[DEPTH-1] = '0;
                end
                OP_REPLACE: begin
                    // Pop followed by an overwrite of the new top, so that
                    // b ends up holding the old entry 2.
                    for (int i = 1; i < DEPTH - 1; i++) begin
                        stk_nxt[i] = stk[i+1];
                    end
                    stk_nxt[DEPTH-1] = '0;
                    stk_nxt[0]       = w;
                end
                OP_SWAP: begin
                    stk_nxt[0] = stk[1];
                    stk_nxt[1] = stk[0];
                end
                default: begin
                    stk_nxt[0] = stk[0];
                end
            endcase
        end
    end

    // Occupancy update and error detection. Both are based on the count
    // value from before the op.
    always_comb begin
        cnt_nxt = cnt;
        ovf_set = 1'b0;
        unf_set = 1'b0;
        case (stackOP)
            OP_PUSH: begin
                ovf_set = (cnt == CNT_MAX);
                cnt_nxt = (cnt == CNT_MAX) ? CNT_MAX : cnt + CNT_ONE;
            end
            OP_DUP: begin
                ovf_set = (cnt == CNT_MAX);
                unf_set = (cnt == CNT_ZERO);
                cnt_nxt = (cnt == CNT_MAX) ? CNT_MAX : cnt + CNT_ONE;
            end
            OP_OVER: begin
                ovf_set = (cnt == CNT_MAX);
                unf_set = (cnt < CNT_TWO);
                cnt_nxt = (cnt == CNT_MAX) ? CNT_MAX : cnt + CNT_ONE;
            end
            OP_POP: begin
                unf_set = (cnt == CNT_ZERO);
                cnt_nxt = (cnt == CNT_ZERO) ? CNT_ZERO : cnt - CNT_ONE;
            end
            OP_POP2: begin
                unf_set = (cnt < CNT_TWO);
                cnt_nxt = (cnt < CNT_TWO) ? CNT_ZERO : cnt - CNT_TWO;
            end
            OP_REPLACE: begin
                // REPLACE always leaves at least the written word valid.
                unf_set = (cnt < CNT_TWO);
                cnt_nxt = (cnt <= CNT_TWO) ? CNT_ONE : cnt - CNT_ONE;
            end
            OP_SWAP: begin
                unf_set = (cnt < CNT_TWO);
            end
            OP_NOP: begin
                cnt_nxt = cnt;
            end
            default: begin
                cnt_nxt = cnt;
            end
        endcase
    end

    // Storage registers, cleared asynchronously.
    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                stk[i] <= '0;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                stk[i] <= stk_nxt[i];
            end
        end
    end

    // Entry count register.
    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            cnt <= '0;
        end else begin
            cnt <= cnt_nxt;
        end
    end

    // Sticky error flags. A new error in the same cycle as clr_err wins
    // over the clear.
    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            ovf <= 1'b0;
            unf <= 1'b0;
        end else begin
            ovf <= (ovf & ~clr_err) | ovf_set;
            unf <= (unf & ~clr_err) | unf_set;
        end
    end

    assign a     = stk[0];
    assign b     = stk[1];
    assign count = cnt;
    assign full  = (cnt == CNT_MAX);
    assign empty = (cnt == CNT_ZERO);

endmodule

// File: tb/tb_register_stack_param.sv
// Testbench for register_stack_param. It uses a default 16x64 instance and
// an 8x4 instance. Expected values come from a queue-based model of the
// stack contents and the occupancy rules.
module tb_register_stack_param;

    localparam int OP_NOP = 0, OP_PUSH = 1, OP_REPLACE = 2, OP_POP = 3;
    localparam int OP_POP2 = 4, OP_SWAP = 5, OP_DUP = 6, OP_OVER = 7;

    logic        CLK;
    logic        rst;
    logic [2:0]  op64, op4;
    logic [15:0] w64;
    logic [7:0]  w4;
    logic        clr64, clr4;
    logic [15:0] a64, b64;
    logic [7:0]  a4, b4;
    logic [6:0]  cnt64;
    logic [2:0]  cnt4;
    logic        full64, empty64, ovf64, unf64;
    logic        full4, empty4, ovf4, unf4;

    register_stack_param dut64 (
        .CLK(CLK), .reset(rst), .stackOP(op64), .w(w64), .clr_err(clr64),
        .a(a64), .b(b64), .count(cnt64), .full(full64), .empty(empty64),
        .ovf(ovf64), .unf(unf64)
    );

    register_stack_param #(.WIDTH(8), .DEPTH(4)) dut4 (
        .CLK(CLK), .reset(rst), .stackOP(op4), .w(w4), .clr_err(clr4),
        .a(a4), .b(b4), .count(cnt4), .full(full4), .empty(empty4),
        .ovf(ovf4), .unf(unf4)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int nchk = 0;
    int nerr = 0;

    // Model state for whichever instance is currently being exercised.
    int  mq[$];
    int  mcnt;
    int  mdepth;
    int  mmask;
    bit  movf, munf;
    bit  sel4;

    task automatic chk(input string tag, input int got, input int exp);
        nchk++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        for (int i = 0; i < mdepth; i++) mq.push_back(0);
        mcnt = 0;
        movf = 0;
        munf = 0;
    endtask

    task automatic model_op(input int op, input int wv, input bit clr);
        int need;
        int v;
        need = 0;
        if (clr) begin
            movf = 0;
            munf = 0;
        end
        case (op)
            OP_POP, OP_DUP:                    need = 1;
            OP_POP2, OP_REPLACE, OP_SWAP, OP_OVER: need = 2;
            default:                           need = 0;
        endcase
        if (mcnt < need) munf = 1;
        if ((op == OP_PUSH || op == OP_DUP || op == OP_OVER) && mcnt == mdepth) movf = 1;
        case (op)
            OP_PUSH, OP_DUP, OP_OVER: begin
                v = (op == OP_PUSH) ? wv : (op == OP_DUP) ? mq[0] : mq[1];
                mq.push_front(v);
                void'(mq.pop_back());
                if (mcnt < mdepth) mcnt++;
            end
            OP_POP: begin
                void'(mq.pop_front());
                mq.push_back(0);
                if (mcnt > 0) mcnt--;
            end
            OP_POP2: begin
                void'(mq.pop_front());
                void'(mq.pop_front());
                mq.push_back(0);
                mq.push_back(0);
                mcnt = (mcnt < 2) ? 0 : mcnt - 2;
            end
            OP_REPLACE: begin
                void'(mq.pop_front());
                mq.push_back(0);
                mq[0] = wv;
                mcnt = (mcnt - 1 > 1) ? mcnt - 1 : 1;
            end
            OP_SWAP: begin
                v     = mq[0];
                mq[0] = mq[1];
                mq[1] = v;
            end
            default: ;
        endcase
    endtask

    task automatic compare_all(input string pfx);
        if (sel4) begin
            chk({pfx, " a"}, int'(a4), mq[0]);
            chk({pfx, " b"}, int'(b4), mq[1]);
            chk({pfx, " count"}, int'(cnt4), mcnt);
            chk({pfx, " full"}, int'(full4), int'(mcnt == mdepth));
            chk({pfx, " empty"}, int'(empty4), int'(mcnt == 0));
            chk({pfx, " ovf"}, int'(ovf4), int'(movf));
            chk({pfx, " unf"}, int'(unf4), int'(munf));
        end else begin
            chk({pfx, " a"}, int'(a64), mq[0]);
            chk({pfx, " b"}, int'(b64), mq[1]);
            chk({pfx, " count"}, int'(cnt64), mcnt);
            chk({pfx, " full"}, int'(full64), int'(mcnt == mdepth));
            chk({pfx, " empty"}, int'(empty64), int'(mcnt == 0));
            chk({pfx, " ovf"}, int'(ovf64), int'(movf));
            chk({pfx, " unf"}, int'(unf64), int'(munf));
        end
    endtask

    // Apply one op at the next rising edge, then check shortly after it.
    task automatic step(input int op, input int wv, input bit clr);
        int wm;
        wm = wv & mmask;
        if (sel4) begin
            op4 = op[2:0]; w4 = wm[7:0]; clr4 = clr;
        end else begin
            op64 = op[2:0]; w64 = wm[15:0]; clr64 = clr;
        end
        @(posedge CLK);
        #1;
        op64 = '0; op4 = '0; clr64 = 1'b0; clr4 = 1'b0;
        model_op(op, wm, clr);
        compare_all($sformatf("op%0d", op));
    endtask

    task automatic do_reset();
        @(negedge CLK);
        rst = 1'b1;
        @(negedge CLK);
        rst = 1'b0;
        model_reset();
        compare_all("after reset");
    endtask

    task automatic random_ops(input int n);
        int op;
        bit clr;
        for (int i = 0; i < n; i++) begin
            op  = $urandom_range(0, 7);
            clr = ($urandom_range(0, 15) == 0);
            step(op, $urandom, clr);
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        rst = 1'b1;
        op64 = '0; op4 = '0; w64 = '0; w4 = '0; clr64 = 1'b0; clr4 = 1'b0;
        sel4 = 0; mdepth = 64; mmask = 32'h0000_ffff;
        model_reset();
        #12;
        compare_all("reset64");
        chk("reset4 a", int'(a4), 0);
        chk("reset4 count", int'(cnt4), 0);
        chk("reset4 empty", int'(empty4), 1);
        @(negedge CLK);
        rst = 1'b0;

        // PUSH 1, PUSH 4, REPLACE 5
        step(OP_PUSH, 1, 0);
        step(OP_PUSH, 4, 0);
        step(OP_REPLACE, 5, 0);
        chk("replace a", int'(a64), 5);
        chk("replace b", int'(b64), 0);
        chk("replace count", int'(cnt64), 1);
        chk("replace unf", int'(unf64), 0);

        // POP down past empty, then clear the flag
        do_reset();
        step(OP_PUSH, 2, 0);
        step(OP_PUSH, 4, 0);
        step(OP_POP, 0, 0);
        chk("pop a", int'(a64), 2);
        step(OP_POP, 0, 0);
        chk("pop empty unf", int'(unf64), 0);
        step(OP_POP, 0, 0);
        chk("pop under unf", int'(unf64), 1);
        step(OP_NOP, 0, 1);
        chk("clr unf", int'(unf64), 0);

        // SWAP, OVER, DUP
        do_reset();
        step(OP_PUSH, 1, 0);
        step(OP_PUSH, 2, 0);
        step(OP_SWAP, 0, 0);
        chk("swap a", int'(a64), 1);
        chk("swap b", int'(b64), 2);
        step(OP_OVER, 0, 0);
        chk("over a", int'(a64), 2);
        chk("over count", int'(cnt64), 3);
        step(OP_DUP, 0, 0);
        chk("dup b", int'(b64), 2);
        chk("dup count", int'(cnt64), 4);

        // POP2 sequence
        do_reset();
        step(OP_PUSH, 2, 0);
        step(OP_PUSH, 4, 0);
        step(OP_PUSH, 3, 0);
        step(OP_PUSH, 5, 0);
        step(OP_POP2, 0, 0);
        chk("pop2 a", int'(a64), 4);
        step(OP_POP2, 0, 0);
        chk("pop2 unf clear", int'(unf64), 0);
        step(OP_POP2, 0, 0);
        chk("pop2 unf set", int'(unf64), 1);

        // Fill, overflow, drain
        do_reset();
        for (int i = 1; i <= 64; i++) step(OP_PUSH, i, 0);
        chk("fill full", int'(full64), 1);
        chk("fill ovf", int'(ovf64), 0);
        step(OP_PUSH, 65, 0);
        chk("over ovf", int'(ovf64), 1);
        chk("over count", int'(cnt64), 64);
        for (int i = 0; i < 63; i++) step(OP_POP, 0, 0);
        chk("drain a", int'(a64), 2);
        step(OP_POP, 0, 0);
        chk("drain last a", int'(a64), 0);
        chk("drain empty", int'(empty64), 1);

        // Clear and a new error in the same cycle: the new error stays set
        step(OP_POP, 0, 1);
        chk("clr vs set unf", int'(unf64), 1);
        chk("clr vs set ovf", int'(ovf64), 0);

        // Asynchronous reset between clock edges
        do_reset();
        step(OP_PUSH, 7, 0);
        #2;
        rst = 1'b1;
        #1;
        chk("async rst a", int'(a64), 0);
        chk("async rst count", int'(cnt64), 0);
        chk("async rst empty", int'(empty64), 1);
        @(negedge CLK);
        rst = 1'b0;
        model_reset();
        step(OP_PUSH, 9, 0);
        chk("post rst push a", int'(a64), 9);

        random_ops(400);

        // 8-bit, 4-deep instance
        sel4 = 1; mdepth = 4; mmask = 32'h0000_00ff;
        do_reset();
        for (int i = 0; i < 5; i++) step(OP_PUSH, 255, 0);
        chk("d4 ovf", int'(ovf4), 1);
        chk("d4 count", int'(cnt4), 4);
        chk("d4 a", int'(a4), 255);
        for (int i = 0; i < 5; i++) step(OP_PUSH, 1, 0);
        chk("d4 ovf again", int'(ovf4), 1);
        chk("d4 a one", int'(a4), 1);
        random_ops(400);

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
